dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Data-memory responder for the single-cycle MIPS core. It sits on the far side of the datapath's memory interface and services the core's ALU-result address, store data and write enable.
- It returns read data combinationally within the same cycle, so the core needs no stall.
- It contains a word-addressed RAM, a small memory-mapped register bank (cycle counter, store counter, output port, fault status) and a valid/ready host port for preloading RAM.

Parameters:
- DEPTH_LOG2, 8: RAM holds 2^DEPTH_LOG2 32-bit words at word addresses 0 .. 2^DEPTH_LOG2-1.
- MMIO_BASE, 32'h8000_0000: word address of the first MMIO register. MMIO occupies MMIO_BASE .. MMIO_BASE+3.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- addr  in  32  word address from the core (the ALU result).
- write_data  in  32  store data from the core (register rt value).
- mem_write  in  1  core store enable.
- read_data  out  32  combinational load data to the core.
- host_valid  in  1  host write request.
- host_ready  out  1  host write accepted this cycle when host_valid is also high.
- host_addr  in  32  host word address.
- host_data  in  32  host write data.
- out_port  out  32  value of the OUT register.
- out_valid  out  1  one-cycle pulse after each OUT write.
- fault  out  3  FAULT register contents.

Behaviour:
- One clock domain. Reset is asynchronous and active-high.
- Reset values:
  - CYCLE = 0, STORES = 0, OUT = 0.
  - out_valid = 0, FAULT = 3'b000.
  - RAM contents are NOT reset.
- Address decode on addr:
  - RAM region: addr < 2^DEPTH_LOG2.
  - MMIO region: MMIO_BASE+0 CYCLE (read-only), +1 STORES (read-only), +2 OUT (read/write), +3 FAULT (read; a write clears it).
  - Every other address is unmapped.
- Reads are combinational, with zero latency and no dependence on mem_write:
  - RAM region: RAM word.
  - MMIO region: register value.
  - Unmapped address: 32'h0000_0000.
  - Read-during-write to the same address returns the old value; the new value is visible the next cycle.
- CPU stores (mem_write=1), committed at the clock edge:
  - RAM region: write the word and increment STORES (wraps 0xFFFF_FFFF -> 0).
  - OUT: load OUT from write_data and drive out_valid=1 for exactly the following cycle.
  - FAULT: clear all bits.
  - CYCLE, STORES or an unmapped address: write dropped, FAULT[1] set. Exception: addresses >= 2^DEPTH_LOG2 and outside MMIO set FAULT[0] instead.
  - STORES counts only accepted CPU RAM stores.
- CYCLE increments every cycle out of reset and wraps to 0. A read returns the pre-edge value.
- Host port:
  - host_ready = !mem_write. The CPU always wins the RAM write port.
  - A transfer occurs when host_valid && host_ready. host_data is written at host_addr at that edge.
  - Host writes do not change STORES or OUT.
  - host_addr >= 2^DEPTH_LOG2 on a transfer: data dropped, FAULT[2] set. The host port cannot reach MMIO.
  - If host_valid is held while ready is low, the host must hold addr/data stable until ready is high.
- Simultaneous events:
  - A CPU write to FAULT in the same cycle as a new fault: the new fault bit ends set; all other bits clear.
  - Host and CPU are never both written in one cycle, by construction.
- FAULT bits are sticky until a CPU write to FAULT or reset.
- Reset asserted mid-operation:
  - Counters, OUT, out_valid and FAULT clear immediately (asynchronously).
  - A store presented in the same cycle as reset is not committed.
  - RAM keeps its prior contents.

Test Plan:
- Reset, then run 10 cycles with mem_write=0 and addr=MMIO_BASE. Required: read_data steps 0..9 one per cycle; out_port=0; fault=0.
- Host writes 0x1234_5678 to word 5 with mem_write=0, then the CPU reads addr=5. Required: host_ready=1, read_data=0x1234_5678, STORES stays 0.
- CPU stores 0xCAFE_F00D to word 7 while host_valid=1 targets word 9 in the same cycle. Required:
  - host_ready=0 that cycle and word 7 = 0xCAFE_F00D.
  - Host write lands at word 9 on the next cycle.
  - STORES reads 1.
- CPU stores 0xA5 to MMIO_BASE+2. Required: out_port=0xA5 and out_valid=1 for exactly one cycle after the edge.
- CPU stores to addr 0x0000_0100 with DEPTH_LOG2=8, then stores to MMIO_BASE+0. Required:
  - fault=3'b011.
  - CYCLE keeps counting.
  - A CPU store to MMIO_BASE+3 in the same cycle as a host write to 0x200 leaves fault=3'b100.
- Assert reset mid-run after 3 RAM stores and an OUT write. Required: STORES=0, OUT=0, CYCLE=0 and fault=0 immediately, while the RAM words still read their stored values.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder for the single-cycle MIPS core: word RAM with a combinational
// read port, a four-register MMIO bank, and a host preload port.
module dmem_responder #(
    parameter int          DEPTH_LOG2 = 8,
    parameter logic [31:0] MMIO_BASE  = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] write_data,
    input  logic        mem_write,
    output logic [31:0] read_data,
    input  logic        host_valid,
    output logic        host_ready,
    input  logic [31:0] host_addr,
    input  logic [31:0] host_data,
    output logic [31:0] out_port,
    output logic        out_valid,
    output logic [2:0]  fault
);

    localparam logic [31:0] DEPTH = 32'(1) << DEPTH_LOG2;

    logic [31:0] mem [DEPTH];

    logic [31:0] cycle_cnt;
    logic [31:0] store_cnt;
    logic [31:0] out_reg;
    logic        out_pulse;
    logic [2:0]  fault_reg;

    logic [31:0]           mmio_off;
    logic                  ram_hit;
    logic                  mmio_hit;
    logic [1:0]            reg_sel;
    logic [DEPTH_LOG2-1:0] cpu_idx;
    logic [DEPTH_LOG2-1:0] host_idx;
    logic                  host_fire;
    logic                  host_in_ram;
    logic                  cpu_ram_wr;
    logic                  out_wr;
    logic                  fault_clr;
    logic [2:0]            fault_set;

    assign mmio_off = addr - MMIO_BASE;
    assign ram_hit  = addr < DEPTH;
    assign mmio_hit = mmio_off < 32'd4;
    assign reg_sel  = mmio_off[1:0];
    assign cpu_idx  = addr[DEPTH_LOG2-1:0];
    assign host_idx = host_addr[DEPTH_LOG2-1:0];

    // Host handshake: a transfer happens on a rising edge where host_valid && host_ready.
    // host_ready drops whenever the core stores, so the core owns the RAM write port;
    // a stalled host keeps host_valid, host_addr and host_data stable until accepted.
    assign host_ready  = !mem_write;
    assign host_fire   = host_valid && host_ready;
    assign host_in_ram = host_addr < DEPTH;

    assign cpu_ram_wr = mem_write && ram_hit;
    assign out_wr     = mem_write && mmio_hit && (reg_sel == 2'd2);
    assign fault_clr  = mem_write && mmio_hit && (reg_sel == 2'd3);

    // Bit 0: store outside RAM and MMIO; bit 1: store to a read-only counter;
    // bit 2: host write beyond RAM.
    assign fault_set[0] = mem_write && !ram_hit && !mmio_hit;
    assign fault_set[1] = mem_write && mmio_hit && !reg_sel[1];
    assign fault_set[2] = host_fire && !host_in_ram;

    always_comb begin
        read_data = 32'h0000_0000;
        if (ram_hit) begin
            read_data = mem[cpu_idx];
        end else if (mmio_hit) begin
            case (reg_sel)
                2'd0:    read_data = cycle_cnt;
                2'd1:    read_data = store_cnt;
                2'd2:    read_data = out_reg;
                default: read_data = {29'd0, fault_reg};
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_cnt <= '0;
            store_cnt <= '0;
            out_reg   <= '0;
            out_pulse <= 1'b0;
            fault_reg <= 3'b000;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (cpu_ram_wr) begin
                store_cnt <= store_cnt + 32'd1;
            end
            if (out_wr) begin
                out_reg <= write_data;
            end
            out_pulse <= out_wr;
            // A clear and a fresh fault in the same cycle leave only the fresh bit set.
            fault_reg <= (fault_clr ? 3'b000 : fault_reg) | fault_set;
        end
    end

    // RAM is never cleared; a store presented while reset is high is not committed.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (cpu_ram_wr) begin
                mem[cpu_idx] <= write_data;
            end else if (host_fire && host_in_ram) begin
                mem[host_idx] <= host_data;
            end
        end
    end

    assign out_port  = out_reg;
    assign out_valid = out_pulse;
    assign fault     = fault_reg;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder: counters, host port, OUT pulse,
// fault bits and mid-run reset.
module tb_dmem_responder;

    localparam logic [31:0] MMIO_BASE = 32'h8000_0000;

    logic        clk;
    logic        reset;
    logic [31:0] addr;
    logic [31:0] write_data;
    logic        mem_write;
    logic [31:0] read_data;
    logic        host_valid;
    logic        host_ready;
    logic [31:0] host_addr;
    logic [31:0] host_data;
    logic [31:0] out_port;
    logic        out_valid;
    logic [2:0]  fault;

    int unsigned n_cmp;
    int unsigned n_err;
    logic [31:0] exp_cycle;
    logic [31:0] exp_stores;
    logic [31:0] exp_q[$];
    logic [31:0] addr_q[$];

    dmem_responder #(.DEPTH_LOG2(8), .MMIO_BASE(MMIO_BASE)) dut (
        .clk(clk), .reset(reset), .addr(addr), .write_data(write_data),
        .mem_write(mem_write), .read_data(read_data), .host_valid(host_valid),
        .host_ready(host_ready), .host_addr(host_addr), .host_data(host_data),
        .out_port(out_port), .out_valid(out_valid), .fault(fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and settle 1 ns past it; the bench mirrors CYCLE independently.
    task automatic tick();
        @(posedge clk);
        #1;
        if (!reset) exp_cycle = exp_cycle + 32'd1;
    endtask

    task automatic test_reset();
        reset = 1'b1; mem_write = 1'b0; addr = MMIO_BASE; write_data = '0;
        host_valid = 1'b0; host_addr = '0; host_data = '0;
        exp_cycle = '0; exp_stores = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            n_cmp++;
            if (read_data !== 32'(i)) begin
                n_err++;
                $display("FAIL cycle_step%0d: got %h want %h", i, read_data, 32'(i));
            end
            n_cmp++;
            if (out_port !== 32'h0 || fault !== 3'b000 || out_valid !== 1'b0) begin
                n_err++;
                $display("FAIL reset_regs%0d: out_port %h out_valid %b fault %b want 0/0/000", i, out_port, out_valid, fault);
            end
            tick();
        end
    endtask

    task automatic test_host_write();
        addr = 32'd5; host_valid = 1'b1; host_addr = 32'd5; host_data = 32'h1234_5678;
        #1;
        n_cmp++;
        if (host_ready !== 1'b1) begin
            n_err++;
            $display("FAIL host_ready_idle: got %b want 1", host_ready);
        end
        tick();
        host_valid = 1'b0;
        exp_q.push_back(32'h1234_5678); addr_q.push_back(32'd5);
        #1;
        n_cmp++;
        if (read_data !== 32'h1234_5678) begin
            n_err++;
            $display("FAIL host_word5: got %h want 12345678", read_data);
        end
        addr = MMIO_BASE + 32'd1;
        #1;
        n_cmp++;
        if (read_data !== 32'd0) begin
            n_err++;
            $display("FAIL stores_after_host: got %h want 0", read_data);
        end
    endtask

    task automatic test_back_to_back();
        addr = 32'd7; write_data = 32'hCAFE_F00D; mem_write = 1'b1;
        host_valid = 1'b1; host_addr = 32'd9; host_data = 32'h0000_0099;
        #1;
        n_cmp++;
        if (host_ready !== 1'b0) begin
            n_err++;
            $display("FAIL host_ready_cpu_store: got %b want 0", host_ready);
        end
        tick();
        mem_write = 1'b0;
        exp_stores = exp_stores + 32'd1;
        exp_q.push_back(32'hCAFE_F00D); addr_q.push_back(32'd7);
        #1;
        n_cmp++;
        if (host_ready !== 1'b1 || read_data !== 32'hCAFE_F00D) begin
            n_err++;
            $display("FAIL word7_store: ready %b data %h want 1/cafef00d", host_ready, read_data);
        end
        tick();
        host_valid = 1'b0;
        exp_q.push_back(32'h0000_0099); addr_q.push_back(32'd9);
        addr = 32'd9;
        #1;
        n_cmp++;
        if (read_data !== 32'h0000_0099) begin
            n_err++;
            $display("FAIL word9_delayed_host: got %h want 00000099", read_data);
        end
        addr = MMIO_BASE + 32'd1;
        #1;
        n_cmp++;
        if (read_data !== exp_stores) begin
            n_err++;
            $display("FAIL stores_count: got %h want %h", read_data, exp_stores);
        end
    endtask

    task automatic test_out_pulse();
        addr = MMIO_BASE + 32'd2; write_data = 32'h0000_00A5; mem_write = 1'b1;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || read_data !== 32'h0) begin
            n_err++;
            $display("FAIL out_pre_edge: valid %b data %h want 0/0", out_valid, read_data);
        end
        tick();
        mem_write = 1'b0;
        #1;
        n_cmp++;
        if (out_port !== 32'hA5 || out_valid !== 1'b1 || read_data !== 32'hA5) begin
            n_err++;
            $display("FAIL out_write: port %h valid %b read %h want a5/1/a5", out_port, out_valid, read_data);
        end
        tick();
        n_cmp++;
        if (out_valid !== 1'b0 || out_port !== 32'hA5) begin
            n_err++;
            $display("FAIL out_pulse_end: valid %b port %h want 0/a5", out_valid, out_port);
        end
    endtask

    task automatic test_faults();
        addr = 32'h0000_0100; write_data = 32'h1111_1111; mem_write = 1'b1;
        tick();
        #1;
        n_cmp++;
        if (fault !== 3'b001) begin
            n_err++;
            $display("FAIL fault_unmapped: got %b want 001", fault);
        end
        addr = MMIO_BASE;
        tick();
        mem_write = 1'b0;
        #1;
        n_cmp++;
        if (fault !== 3'b011) begin
            n_err++;
            $display("FAIL fault_readonly: got %b want 011", fault);
        end
        n_cmp++;
        if (read_data !== exp_cycle) begin
            n_err++;
            $display("FAIL cycle_after_ro_store: got %h want %h", read_data, exp_cycle);
        end
        addr = MMIO_BASE + 32'd1;
        #1;
        n_cmp++;
        if (read_data !== exp_stores) begin
            n_err++;
            $display("FAIL stores_unchanged_by_faults: got %h want %h", read_data, exp_stores);
        end
        addr = MMIO_BASE + 32'd3; mem_write = 1'b1;
        host_valid = 1'b1; host_addr = 32'h0000_0200; host_data = 32'h2222_2222;
        #1;
        n_cmp++;
        if (host_ready !== 1'b0 || read_data !== 32'h3) begin
            n_err++;
            $display("FAIL fault_clear_setup: ready %b read %h want 0/3", host_ready, read_data);
        end
        tick();
        mem_write = 1'b0;
        #1;
        n_cmp++;
        if (fault !== 3'b000) begin
            n_err++;
            $display("FAIL fault_cleared: got %b want 000", fault);
        end
        tick();
        host_valid = 1'b0;
        #1;
        n_cmp++;
        if (fault !== 3'b100 || read_data !== 32'h4) begin
            n_err++;
            $display("FAIL fault_host_range: fault %b read %h want 100/4", fault, read_data);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [31:0] wa [3];
        logic [31:0] wd [3];
        wa[0] = 32'd1; wa[1] = 32'd2; wa[2] = 32'd4;
        wd[0] = 32'h0101_0101; wd[1] = 32'h0202_0202; wd[2] = 32'h0404_0404;
        for (int i = 0; i < 3; i++) begin
            addr = wa[i]; write_data = wd[i]; mem_write = 1'b1;
            tick();
            exp_q.push_back(wd[i]); addr_q.push_back(wa[i]);
        end
        addr = MMIO_BASE + 32'd2; write_data = 32'h0000_005A;
        tick();
        addr = 32'd4; write_data = 32'hDEAD_BEEF;
        reset = 1'b1;
        #1;
        n_cmp++;
        if (out_port !== 32'h0 || out_valid !== 1'b0 || fault !== 3'b000) begin
            n_err++;
            $display("FAIL async_reset_regs: port %h valid %b fault %b want 0/0/000", out_port, out_valid, fault);
        end
        for (int r = 0; r < 2; r++) begin
            addr = MMIO_BASE + 32'(r);
            #1;
            n_cmp++;
            if (read_data !== 32'h0) begin
                n_err++;
                $display("FAIL async_reset_reg%0d: got %h want 0", r, read_data);
            end
        end
        addr = 32'd4;
        tick();
        mem_write = 1'b0;
        reset = 1'b0;
        exp_cycle = '0;
        while (exp_q.size() > 0) begin
            logic [31:0] a;
            logic [31:0] d;
            a = addr_q.pop_front();
            d = exp_q.pop_front();
            addr = a;
            #1;
            n_cmp++;
            if (read_data !== d) begin
                n_err++;
                $display("FAIL ram_kept_word%0d: got %h want %h", a, read_data, d);
            end
        end
        addr = MMIO_BASE;
        #1;
        n_cmp++;
        if (read_data !== exp_cycle) begin
            n_err++;
            $display("FAIL cycle_after_reset: got %h want %h", read_data, exp_cycle);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_host_write();
        test_back_to_back();
        test_out_pulse();
        test_faults();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
